// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: LFSR random generator (Fibonacci/Galois) with serial seed load and req/valid/ready output.
// Define LFSR_WRAP_DET_EN to add the o_wrap period-complete pulse.
module lfsr_prng_gen #(
    parameter int WIDTH = 8,
    parameter int MODE = 0,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] GPOLY = WIDTH'(8'h1D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_req,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_rand,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_run,
`ifdef LFSR_WRAP_DET_EN
    output logic             o_wrap,
`endif
    output logic             o_seed_fix
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] lfsr, shadow, step_nx;
    logic [CW-1:0] cnt;
    logic load_go, cap;
    always_comb begin
        load_go = i_load && state != LOAD;
        cap = state == RUN && i_req && !i_load && (!o_valid || i_ready);
        step_nx = (MODE == 1) ? ({lfsr[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr[WIDTH-1]}} & GPOLY))
                              : {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        state_nx = load_go ? LOAD : (state == LOAD && cnt == LAST) ? RUN : state;
    end
    assign o_busy = state == LOAD;
    assign o_run = state == RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lfsr <= '0;
            shadow <= '0;
            cnt <= '0;
            o_rand <= '0;
            o_valid <= 1'b0;
            o_seed_fix <= 1'b0;
`ifdef LFSR_WRAP_DET_EN
            o_wrap <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (load_go) begin
                // an all-zero seed would lock the LFSR, so substitute 1
                shadow <= (i_seed == '0) ? WIDTH'(1) : i_seed;
                o_seed_fix <= i_seed == '0;
                cnt <= '0;
            end else if (state == LOAD) begin
                lfsr <= {lfsr[WIDTH-2:0], shadow[LAST-cnt]};
                cnt <= cnt + 1'b1;
            end else if (state == RUN && i_en) begin
                lfsr <= step_nx;
            end
            if (cap) begin
                o_rand <= lfsr;
                o_valid <= 1'b1;
            end else if (load_go || (o_valid && i_ready)) begin
                o_valid <= 1'b0;
            end
`ifdef LFSR_WRAP_DET_EN
            o_wrap <= state == RUN && i_en && !i_load && step_nx == shadow;
`endif
        end
    end
endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb_lfsr_prng_gen: directed scoreboard bench running a Fibonacci and a Galois instance side by side.
module tb_lfsr_prng_gen;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] i_seed = '0;
    logic i_load = 0, i_en = 0, i_req = 0, i_ready = 0;
    logic [7:0] rand_f, rand_g;
    logic valid_f, valid_g, busy_f, busy_g, run_f, run_g, fix_f, fix_g;
`ifdef LFSR_WRAP_DET_EN
    logic wrap_f, wrap_g;
`endif
    int total = 0, bad = 0;
    logic [7:0] mf, mg, held;
    logic [7:0] qf[$], qg[$];

    always #5 clk = ~clk;

    lfsr_prng_gen #(.WIDTH(8), .MODE(0)) u_f (
        .clk(clk), .rst(rst), .i_seed(i_seed), .i_load(i_load), .i_en(i_en), .i_req(i_req),
        .i_ready(i_ready), .o_rand(rand_f), .o_valid(valid_f), .o_busy(busy_f), .o_run(run_f),
`ifdef LFSR_WRAP_DET_EN
        .o_wrap(wrap_f),
`endif
        .o_seed_fix(fix_f));
    lfsr_prng_gen #(.WIDTH(8), .MODE(1)) u_g (
        .clk(clk), .rst(rst), .i_seed(i_seed), .i_load(i_load), .i_en(i_en), .i_req(i_req),
        .i_ready(i_ready), .o_rand(rand_g), .o_valid(valid_g), .o_busy(busy_g), .o_run(run_g),
`ifdef LFSR_WRAP_DET_EN
        .o_wrap(wrap_g),
`endif
        .o_seed_fix(fix_g));

    function automatic logic [7:0] fib(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
    function automatic logic [7:0] gal(input logic [7:0] s);
        return s[7] ? ({s[6:0], 1'b0} ^ 8'h1D) : {s[6:0], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // cap: this edge captures a value; adv: this edge steps the LFSR
    task automatic cyc(input bit cap, input bit adv);
        if (cap) begin
            qf.push_back(mf);
            qg.push_back(mg);
        end
        if (adv) begin
            mf = fib(mf);
            mg = gal(mg);
        end
        tick;
        if (cap) begin
            chk("valid_f", valid_f, 1);
            chk("valid_g", valid_g, 1);
            chk("rand_f", rand_f, (qf.size() != 0) ? qf.pop_front() : 8'hxx);
            chk("rand_g", rand_g, (qg.size() != 0) ? qg.pop_front() : 8'hxx);
        end
    endtask

    task automatic load(input logic [7:0] seed);
        int n = 0;
        i_seed = seed;
        i_load = 1;
        tick;
        i_load = 0;
        while (busy_f && n < 40) begin
            n++;
            tick;
        end
        chk("busy_len", n, 8);
        chk("run_f", run_f, 1);
        chk("run_g", run_g, 1);
        mf = (seed == 0) ? 8'h01 : seed;
        mg = mf;
    endtask

    initial begin
        #1;
        chk("rst_rand", rand_f, 0);
        chk("rst_valid", valid_f, 0);
        chk("rst_busy", busy_f, 0);
        chk("rst_run", run_f, 0);
        chk("rst_fix", fix_f, 0);
        tick;
        rst = 0;
        tick;
        chk("idle_run", run_f, 0);
        load(8'h01);
        chk("fix_01", fix_f, 0);
        i_en = 1; i_req = 1; i_ready = 1;
        for (int k = 0; k < 5; k++) cyc(1, 1);
        i_en = 0; i_req = 0;
        tick;
        chk("drop_valid", valid_f, 0);
        chk("q_empty", qf.size(), 0);
        i_ready = 0; i_req = 1;
        cyc(1, 0);
        held = rand_f;
        chk("held_val", held, 8'h23);
        i_en = 1;
        for (int k = 0; k < 5; k++) begin
            i_req = k[0];
            cyc(0, 1);
            chk("bp_rand", rand_f, held);
            chk("bp_valid", valid_f, 1);
        end
        i_req = 0; i_en = 0; i_ready = 1;
        tick;
        chk("ready_drop", valid_f, 0);
        chk("ready_hold", rand_f, held);
        load(8'h80);
        i_req = 1; i_en = 1;
        cyc(1, 1);
        cyc(1, 1);
        chk("gal_1d", rand_g, 8'h1D);
        i_req = 0; i_en = 0;
        tick;
        load(8'h00);
        chk("fix_set_f", fix_f, 1);
        chk("fix_set_g", fix_g, 1);
        i_req = 1;
        cyc(1, 0);
        i_req = 0;
        tick;
        load(8'h5A);
        chk("fix_clr", fix_f, 0);
        i_req = 1;
        cyc(1, 0);
        i_load = 1;
        i_seed = 8'h33;
        tick;
        chk("load_wins", valid_f, 0);
        chk("load_busy", busy_f, 1);
        i_load = 0; i_req = 0;
        tick;
        tick;
        rst = 1;
        #1;
        chk("mid_rand", rand_f, 0);
        chk("mid_busy", busy_f, 0);
        chk("mid_run", run_f, 0);
        chk("mid_fix", fix_f, 0);
        chk("mid_valid", valid_g, 0);
        tick;
        rst = 0;
        tick;
`ifdef LFSR_WRAP_DET_EN
        begin
            int nf = 0, ng = 0, first_f = 0, first_g = 0;
            load(8'h01);
            chk("wrap_idle", wrap_f, 0);
            i_en = 1;
            for (int i = 1; i <= 520; i++) begin
                tick;
                if (wrap_f) begin
                    nf++;
                    if (first_f == 0) first_f = i;
                end
                if (wrap_g) begin
                    ng++;
                    if (first_g == 0) first_g = i;
                end
            end
            i_en = 0;
            chk("wrap_cnt_f", nf, 2);
            chk("wrap_first_f", first_f, 255);
            chk("wrap_cnt_g", ng, 2);
            chk("wrap_first_g", first_g, 255);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
